// File: rtl/mem_preloader_if.sv
// Byte-stream handshake used to feed the memory preloader.
// Source side drives valid/data, loader answers with ready.
interface mem_preloader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/mem_preloader.sv
// Fills a memory window from a byte stream with the core held in reset,
// optionally reads it back against a checksum, then hands the port over.
module mem_preloader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LENGTH     = 256,
  parameter int                    VERIFY     = 1,
  parameter int                    RD_LATENCY = 1,
  parameter int                    CSUM_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  mem_preloader_if.slave        s,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  input  logic                  core_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int VW = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] LAST   = CW'(LENGTH - 1);
  localparam logic [VW-1:0] LEN_V  = VW'(LENGTH);
  localparam logic [VW-1:0] V_LAST = VW'(LENGTH + RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERI,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CW-1:0]           cnt;
  logic [VW-1:0]           vcnt;
  logic [RD_LATENCY-1:0]   vld;
  logic [CSUM_WIDTH-1:0]   csum_load;
  logic [CSUM_WIDTH-1:0]   csum_read;
  logic [CSUM_WIDTH-1:0]   csum_rd_nx;
  logic                    acc;
  logic                    issue;
  logic                    tag;
  logic                    clr;

  assign acc   = (state == S_LOAD) && s.s_valid;
  assign issue = (state == S_VERI) && (vcnt < LEN_V);
  assign tag   = vld[RD_LATENCY-1];
  assign clr   = start && ((state == S_IDLE) ||
                           (state == S_RUN)  ||
                           (state == S_FAIL));

  // Folds in the word returning this cycle so the final compare sees it.
  assign csum_rd_nx = csum_read +
                      (tag ? CSUM_WIDTH'(mem_dout) : '0);

  assign count = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (acc && (cnt == LAST))
          state_nx = (VERIFY != 0) ? S_VERI : S_RUN;
      end
      S_VERI: begin
        if (vcnt == V_LAST)
          state_nx = (csum_rd_nx == csum_load) ? S_RUN : S_FAIL;
      end
      S_RUN:  if (start) state_nx = S_LOAD;
      S_FAIL: if (start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    s.s_ready    = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    mem_we       = 1'b0;
    core_reset_n = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    unique case (state)
      S_LOAD: begin
        s.s_ready = 1'b1;
        busy      = 1'b1;
        mem_addr  = BASE_ADDR + cnt[ADDR_WIDTH-1:0];
        mem_din   = s.s_data;
        mem_we    = s.s_valid;
      end
      S_VERI: begin
        busy     = 1'b1;
        mem_addr = BASE_ADDR + vcnt[ADDR_WIDTH-1:0];
      end
      S_RUN: begin
        core_reset_n = 1'b1;
        done         = 1'b1;
        mem_addr     = core_addr;
        mem_din      = core_din;
        mem_we       = core_we;
      end
      S_FAIL: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      vcnt      <= '0;
      vld       <= '0;
      csum_load <= '0;
      csum_read <= '0;
    end else if (clr) begin
      cnt       <= '0;
      vcnt      <= '0;
      vld       <= '0;
      csum_load <= '0;
      csum_read <= '0;
    end else begin
      if (acc) begin
        cnt       <= cnt + 1'b1;
        csum_load <= csum_load + CSUM_WIDTH'(s.s_data);
      end
      if (state == S_VERI) begin
        vcnt      <= vcnt + 1'b1;
        vld       <= (vld << 1) | RD_LATENCY'(issue);
        csum_read <= csum_rd_nx;
      end
    end
  end

endmodule

// File: tb/tb_mem_preloader.sv
// Directed bench: four loader instances with different windows/modes,
// each backed by a behavioural memory.
module tb_mem_preloader;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: BASE 0200, LEN 4, no verify
  logic        start_a, we_a, cwe_a, crn_a, busy_a, done_a, err_a;
  logic [15:0] addr_a, caddr_a;
  logic [7:0]  din_a, cdin_a, dout_a;
  logic [16:0] cnt_a;
  logic [7:0]  mem_a [0:65535];
  mem_preloader_if #(.DATA_WIDTH(8)) if_a();

  mem_preloader #(
    .BASE_ADDR(16'h0200), .LENGTH(4), .VERIFY(0), .RD_LATENCY(1)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a), .s(if_a),
    .core_addr(caddr_a), .core_din(cdin_a), .core_we(cwe_a),
    .mem_addr(addr_a), .mem_din(din_a), .mem_we(we_a),
    .mem_dout(dout_a), .core_reset_n(crn_a), .busy(busy_a),
    .done(done_a), .error(err_a), .count(cnt_a)
  );

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= din_a;
    dout_a <= mem_a[addr_a];
  end

  // ---------------- instance B: BASE 0100, LEN 8, verify, latency 2
  logic        start_b, we_b, crn_b, busy_b, done_b, err_b, flip_b;
  logic [15:0] addr_b;
  logic [7:0]  din_b, dout_b, r1_b;
  logic [16:0] cnt_b;
  logic [7:0]  mem_b [0:65535];
  logic [7:0]  db [8];
  mem_preloader_if #(.DATA_WIDTH(8)) if_b();

  mem_preloader #(
    .BASE_ADDR(16'h0100), .LENGTH(8), .VERIFY(1), .RD_LATENCY(2)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .s(if_b),
    .core_addr(16'h0000), .core_din(8'h00), .core_we(1'b0),
    .mem_addr(addr_b), .mem_din(din_b), .mem_we(we_b),
    .mem_dout(dout_b), .core_reset_n(crn_b), .busy(busy_b),
    .done(done_b), .error(err_b), .count(cnt_b)
  );

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= din_b;
    r1_b   <= mem_b[addr_b] ^
              ((flip_b && addr_b == 16'h0103) ? 8'h01 : 8'h00);
    dout_b <= r1_b;
  end

  // ---------------- instance C: window wrapping at top of memory
  logic        start_c, we_c, crn_c, busy_c, done_c, err_c;
  logic [15:0] addr_c;
  logic [7:0]  din_c, dout_c;
  logic [16:0] cnt_c;
  logic [7:0]  mem_c [0:65535];
  mem_preloader_if #(.DATA_WIDTH(8)) if_c();

  mem_preloader #(
    .BASE_ADDR(16'hFFFE), .LENGTH(4), .VERIFY(0), .RD_LATENCY(1)
  ) u_c (
    .clk(clk), .reset(reset), .start(start_c), .s(if_c),
    .core_addr(16'h0000), .core_din(8'h00), .core_we(1'b0),
    .mem_addr(addr_c), .mem_din(din_c), .mem_we(we_c),
    .mem_dout(dout_c), .core_reset_n(crn_c), .busy(busy_c),
    .done(done_c), .error(err_c), .count(cnt_c)
  );

  always @(posedge clk) begin
    if (we_c) mem_c[addr_c] <= din_c;
    dout_c <= mem_c[addr_c];
  end

  // ---------------- instance D: LEN 5, sparse valid
  logic        start_d, we_d, crn_d, busy_d, done_d, err_d;
  logic [15:0] addr_d;
  logic [7:0]  din_d, dout_d;
  logic [16:0] cnt_d;
  logic [15:0] wlog_d [8];
  int          wn_d = 0;
  mem_preloader_if #(.DATA_WIDTH(8)) if_d();

  mem_preloader #(
    .BASE_ADDR(16'h0300), .LENGTH(5), .VERIFY(0), .RD_LATENCY(1)
  ) u_d (
    .clk(clk), .reset(reset), .start(start_d), .s(if_d),
    .core_addr(16'h0000), .core_din(8'h00), .core_we(1'b0),
    .mem_addr(addr_d), .mem_din(din_d), .mem_we(we_d),
    .mem_dout(dout_d), .core_reset_n(crn_d), .busy(busy_d),
    .done(done_d), .error(err_d), .count(cnt_d)
  );

  always @(posedge clk) begin
    dout_d <= 8'h00;
    if (we_d) begin
      wlog_d[wn_d & 7] <= addr_d;
      wn_d <= wn_d + 1;
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_b();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if_b.s_valid = 1'b1;
      if_b.s_data  = db[i];
      step();
    end
    if_b.s_valid = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (if_a.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready got %b want 0", if_a.s_ready); end
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", we_a); end
    n_cmp++; if (addr_a !== 16'h0000) begin n_err++; $display("FAIL rst_mem_addr got %h want 0000", addr_a); end
    n_cmp++; if (din_a !== 8'h00) begin n_err++; $display("FAIL rst_mem_din got %h want 00", din_a); end
    n_cmp++; if (crn_a !== 1'b0) begin n_err++; $display("FAIL rst_core_reset_n got %b want 0", crn_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL rst_error got %b want 0", err_a); end
    n_cmp++; if (cnt_a !== 17'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", cnt_a); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_novrfy();
    logic [7:0] d [4];
    d = '{8'hA9, 8'h05, 8'h8D, 8'h00};
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_cmp++; if (if_a.s_ready !== 1'b1) begin n_err++; $display("FAIL load_s_ready got %b want 1", if_a.s_ready); end
    n_cmp++; if (crn_a !== 1'b0) begin n_err++; $display("FAIL load_crn got %b want 0", crn_a); end
    for (int i = 0; i < 4; i++) begin
      if_a.s_valid = 1'b1;
      if_a.s_data  = d[i];
      #1;
      n_cmp++; if (addr_a !== 16'(16'h0200 + i)) begin n_err++; $display("FAIL load_addr%0d got %h want %h", i, addr_a, 16'(16'h0200 + i)); end
      n_cmp++; if (we_a !== 1'b1 || din_a !== d[i]) begin n_err++; $display("FAIL load_wr%0d got we=%b din=%h want we=1 din=%h", i, we_a, din_a, d[i]); end
      n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL load_early_done%0d got %b want 0", i, done_a); end
      step();
    end
    if_a.s_valid = 1'b0;
    n_cmp++; if (done_a !== 1'b1 || crn_a !== 1'b1) begin n_err++; $display("FAIL load_done got done=%b crn=%b want 1 1", done_a, crn_a); end
    n_cmp++; if (cnt_a !== 17'd4) begin n_err++; $display("FAIL load_count got %0d want 4", cnt_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL load_busy got %b want 0", busy_a); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_a[16'h0200 + i] !== d[i]) begin n_err++; $display("FAIL load_mem%0d got %h want %h", i, mem_a[16'h0200 + i], d[i]); end
    end
  endtask

  task automatic test_run_core();
    caddr_a = 16'h0010;
    cdin_a  = 8'h5A;
    cwe_a   = 1'b1;
    #1;
    n_cmp++; if (we_a !== 1'b1 || addr_a !== 16'h0010 || din_a !== 8'h5A) begin n_err++; $display("FAIL core_mux got we=%b addr=%h din=%h want 1 0010 5A", we_a, addr_a, din_a); end
    step();
    cwe_a = 1'b0;
    n_cmp++; if (mem_a[16'h0010] !== 8'h5A) begin n_err++; $display("FAIL core_write got %h want 5A", mem_a[16'h0010]); end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_cmp++; if (crn_a !== 1'b0 || busy_a !== 1'b1) begin n_err++; $display("FAIL reload_crn got crn=%b busy=%b want 0 1", crn_a, busy_a); end
    n_cmp++; if (cnt_a !== 17'd0) begin n_err++; $display("FAIL reload_count got %0d want 0", cnt_a); end
    caddr_a = 16'h0011;
    cdin_a  = 8'h77;
    cwe_a   = 1'b1;
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL core_block got %b want 0", we_a); end
    step();
    cwe_a = 1'b0;
    n_cmp++; if (mem_a[16'h0011] === 8'h77) begin n_err++; $display("FAIL core_block_mem got %h want not 77", mem_a[16'h0011]); end
  endtask

  task automatic test_wrap();
    logic [7:0]  d [4];
    logic [15:0] a [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_c.s_valid = 1'b1;
      if_c.s_data  = d[i];
      #1;
      n_cmp++; if (addr_c !== a[i]) begin n_err++; $display("FAIL wrap_addr%0d got %h want %h", i, addr_c, a[i]); end
      step();
    end
    if_c.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_c[a[i]] !== d[i]) begin n_err++; $display("FAIL wrap_mem%0d got %h want %h", i, mem_c[a[i]], d[i]); end
    end
    n_cmp++; if (done_c !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", done_c); end
  endtask

  task automatic test_sparse_valid();
    int k;
    k = 0;
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if_d.s_valid = (i % 3 == 0) && (k < 5);
      if_d.s_data  = 8'(8'h40 + k);
      #1;
      if (!if_d.s_valid) begin
        n_cmp++; if (cnt_d !== 17'(k)) begin n_err++; $display("FAIL sparse_hold%0d got %0d want %0d", i, cnt_d, k); end
      end
      step();
      if (if_d.s_valid) k++;
    end
    if_d.s_valid = 1'b0;
    n_cmp++; if (done_d !== 1'b1 || cnt_d !== 17'd5) begin n_err++; $display("FAIL sparse_done got done=%b count=%0d want 1 5", done_d, cnt_d); end
    n_cmp++; if (wn_d !== 5) begin n_err++; $display("FAIL sparse_writes got %0d want 5", wn_d); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (wlog_d[j] !== 16'(16'h0300 + j)) begin n_err++; $display("FAIL sparse_waddr%0d got %h want %h", j, wlog_d[j], 16'(16'h0300 + j)); end
    end
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!done_b && !err_b && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_verify();
    logic [31:0] seed;
    int n;
    seed = 32'd33551;
    for (int i = 0; i < 8; i++) begin
      seed  = seed * 32'd1103515245 + 32'd12345;
      db[i] = seed[23:16];
    end
    feed_b();
    n_cmp++; if (busy_b !== 1'b1 || done_b !== 1'b0) begin n_err++; $display("FAIL vfy_enter got busy=%b done=%b want 1 0", busy_b, done_b); end
    n = 0;
    while (!done_b && !err_b && n < 40) begin
      if (n < 8) begin
        n_cmp++; if (addr_b !== 16'(16'h0100 + n) || we_b !== 1'b0) begin n_err++; $display("FAIL vfy_rd%0d got addr=%h we=%b want %h 0", n, addr_b, we_b, 16'(16'h0100 + n)); end
      end
      step();
      n++;
    end
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL vfy_cycles got %0d want 10", n); end
    n_cmp++; if (done_b !== 1'b1 || err_b !== 1'b0 || crn_b !== 1'b1) begin n_err++; $display("FAIL vfy_ok got done=%b err=%b crn=%b want 1 0 1", done_b, err_b, crn_b); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (mem_b[16'h0100 + i] !== db[i]) begin n_err++; $display("FAIL vfy_mem%0d got %h want %h", i, mem_b[16'h0100 + i], db[i]); end
    end
  endtask

  task automatic test_verify_fail();
    int n;
    flip_b = 1'b1;
    feed_b();
    wait_b(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL bad_cycles got %0d want 10", n); end
    n_cmp++; if (err_b !== 1'b1 || done_b !== 1'b0 || crn_b !== 1'b0) begin n_err++; $display("FAIL bad_state got err=%b done=%b crn=%b want 1 0 0", err_b, done_b, crn_b); end
    step();
    step();
    step();
    n_cmp++; if (crn_b !== 1'b0 || err_b !== 1'b1) begin n_err++; $display("FAIL bad_hold got crn=%b err=%b want 0 1", crn_b, err_b); end
    flip_b = 1'b0;
    feed_b();
    wait_b(n);
    n_cmp++; if (done_b !== 1'b1 || err_b !== 1'b0 || crn_b !== 1'b1) begin n_err++; $display("FAIL retry_ok got done=%b err=%b crn=%b want 1 0 1", done_b, err_b, crn_b); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d [3];
    d = '{8'hAA, 8'hBB, 8'hCC};
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_b.s_valid = 1'b1;
      if_b.s_data  = d[i];
      step();
    end
    if_b.s_data = 8'hDD;
    reset = 1'b1;
    #1;
    n_cmp++; if (we_b !== 1'b0) begin n_err++; $display("FAIL mid_nowrite got %b want 0", we_b); end
    step();
    n_cmp++; if (if_b.s_ready !== 1'b0 || we_b !== 1'b0 || addr_b !== 16'h0000 || din_b !== 8'h00) begin n_err++; $display("FAIL mid_port got rdy=%b we=%b addr=%h din=%h want 0 0 0000 00", if_b.s_ready, we_b, addr_b, din_b); end
    n_cmp++; if (crn_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || err_b !== 1'b0) begin n_err++; $display("FAIL mid_flags got crn=%b busy=%b done=%b err=%b want 0 0 0 0", crn_b, busy_b, done_b, err_b); end
    n_cmp++; if (cnt_b !== 17'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", cnt_b); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_b[16'h0100 + i] !== d[i]) begin n_err++; $display("FAIL mid_mem%0d got %h want %h", i, mem_b[16'h0100 + i], d[i]); end
    end
    n_cmp++; if (mem_b[16'h0103] !== db[3]) begin n_err++; $display("FAIL mid_untouched got %h want %h", mem_b[16'h0103], db[3]); end
    if_b.s_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    start_c = 1'b0; start_d = 1'b0;
    caddr_a = '0; cdin_a = '0; cwe_a = 1'b0;
    flip_b  = 1'b0;
    if_a.s_valid = 1'b0; if_a.s_data = '0;
    if_b.s_valid = 1'b0; if_b.s_data = '0;
    if_c.s_valid = 1'b0; if_c.s_data = '0;
    if_d.s_valid = 1'b0; if_d.s_data = '0;
    test_reset();
    test_load_novrfy();
    test_run_core();
    test_wrap();
    test_sparse_valid();
    test_verify();
    test_verify_fail();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_preloader.md
# mem_preloader

Synthesizable memory loader that sits between the program memory and the CPU core. It fills a parametrised address window from a byte-stream handshake while holding the core in reset. It can optionally read the window back and check it against a running checksum. On success it hands the memory port to the core and releases core reset; on a checksum mismatch it keeps the core in reset. This block replaces bench-side manual memory filling: the memory is loaded by logic outside the core, while the core is in reset.

## Interface
Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory word and stream width.
- BASE_ADDR, 16'h0000, first address of the load window.
- LENGTH, 256, number of words loaded; range 1..2^ADDR_WIDTH.
- VERIFY, 1, enables the readback checksum pass when 1.
- RD_LATENCY, 1, memory read latency in cycles; range 1..3.
- CSUM_WIDTH, 16, width of the additive checksum.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a load.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_WIDTH  stream word.
- s_ready  out  1  loader accepts a stream word.
- core_addr  in  ADDR_WIDTH  core memory address.
- core_din  in  DATA_WIDTH  core write data.
- core_we  in  1  core write enable.
- mem_addr  out  ADDR_WIDTH  to memory.
- mem_din  out  DATA_WIDTH  to memory.
- mem_we  out  1  to memory.
- mem_dout  in  DATA_WIDTH  read data from memory.
- core_reset_n  out  1  core reset; 0 holds the core in reset.
- busy  out  1  state is LOAD or VERIFY.
- done  out  1  state is RUN.
- error  out  1  state is FAIL.
- count  out  ADDR_WIDTH+1  number of words accepted in the current load.

## Operation
- States: IDLE, LOAD, VERIFY, RUN, FAIL. Reset enters IDLE.
- Memory port mux (combinational):
  - In RUN: mem_addr/mem_din/mem_we = core_addr/core_din/core_we.
  - In every other state the loader drives the port and core_we is blocked.
- IDLE:
  - core_reset_n=0, s_ready=0.
  - start -> LOAD; clears count, csum_load and csum_read.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid&&s_ready: mem_we=1, mem_addr=BASE_ADDR+count (mod 2^ADDR_WIDTH), mem_din=s_data; csum_load += s_data (mod 2^CSUM_WIDTH); count++.
  - When the word with count==LENGTH-1 is accepted, the next state is VERIFY if VERIFY=1, else RUN.
  - If s_valid is low: no write, and state and count are held.
  - start is ignored.
- VERIFY:
  - Issues one read per cycle at BASE_ADDR+k, k=0..LENGTH-1, with mem_we=0.
  - A RD_LATENCY-deep valid shift register tags returning data; each tagged mem_dout is added to csum_read.
  - After the last tagged return: RUN if csum_read==csum_load, else FAIL.
  - start is ignored.
- RUN:
  - core_reset_n=1, done=1.
  - start -> LOAD (reload): core_reset_n returns to 0 in the same cycle the state changes, and counters and checksums are cleared.
- FAIL:
  - error=1, core_reset_n=0.
  - start -> LOAD with counters and checksums cleared.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. A window that crosses the top of memory continues at address 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all counters and checksums zeroed.
  - Memory contents are not altered.
  - No partial write is issued after reset asserts.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_din=0, core_reset_n=0, busy=0, done=0, error=0, count=0.
- Transitions and handshakes:
  - start sampled in IDLE -> LOAD on the next edge; s_ready rises the cycle after start.
  - Stream handshake completes on a rising edge with s_valid&&s_ready. Zero-bubble acceptance: one word per cycle.
  - The memory write occurs on the same edge the word is accepted; mem_we and mem_din are combinational from s_valid and s_data in LOAD.
- Latency:
  - LOAD lasts at least LENGTH cycles.
  - VERIFY lasts exactly LENGTH+RD_LATENCY cycles.
- done / core_reset_n: asserted the cycle after the final verify compare, or after the final write when VERIFY=0.
- The core observes its first memory cycle in the first RUN cycle.

## Test plan
- VERIFY=0, LENGTH=4, BASE=16'h0200, stream A9 05 8D 00 -> mem[0200..0203]=A9,05,8D,00; count=4; done=1 and core_reset_n=1 four cycles after s_ready rises.
- VERIFY=1, LENGTH=8, random data seeded 33551, RD_LATENCY=2 -> VERIFY lasts 10 cycles, csum matches, done=1, error=0.
- VERIFY=1, bench model flips a bit of mem[BASE+3] on readback -> error=1, core_reset_n stays 0; a following start with correct data -> done=1.
- s_valid pulsed every third cycle, LENGTH=5 -> exactly 5 writes, no duplicate addresses, count held between pulses.
- reset asserted after 3 of 8 words -> IDLE next cycle with all outputs at reset values; mem[BASE..BASE+2] retain their written values.
- BASE=16'hFFFE, LENGTH=4 -> writes go to FFFE, FFFF, 0000, 0001.
- In RUN, a core write to 16'h0010 lands in memory; start during RUN -> core_reset_n=0 in the next cycle and core_we is blocked from then on.
